// File: rtl/dual_port_ram_if.sv
// ----------------------------------------------------------------------------
// Module   : dual_port_ram_if
// Brief    : Write/read/clear bus bundle for dual_port_ram.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

interface dual_port_ram_if #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 32
);
  logic                      clear_req;
  logic                      busy;
  logic                      wr_en;
  logic [ADDR_WIDTH-1:0]     wr_adr;
  logic [DATA_WIDTH-1:0]     wr_data;
  logic [DATA_WIDTH/8-1:0]   wr_be;
  logic                      rd_en;
  logic [ADDR_WIDTH-1:0]     rd_adr;
  logic [DATA_WIDTH-1:0]     rd_data;
  logic                      rd_valid;

  modport master (
    output clear_req, wr_en, wr_adr, wr_data, wr_be, rd_en, rd_adr,
    input  busy, rd_data, rd_valid
  );

  modport slave (
    input  clear_req, wr_en, wr_adr, wr_data, wr_be, rd_en, rd_adr,
    output busy, rd_data, rd_valid
  );
endinterface

`default_nettype wire

// File: rtl/dual_port_ram.sv
// ----------------------------------------------------------------------------
// Module   : dual_port_ram
// Brief    : 1W/1R synchronous RAM with byte enables, registered read and a
//            sequential whole-array clear engine.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

module dual_port_ram #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 32,
  parameter int RDW_MODE   = 0
) (
  input  wire                 clk,
  input  wire                 rst_n,
  dual_port_ram_if.slave      bus
);

  localparam int                    c_DEPTH = 1 << ADDR_WIDTH;
  localparam int                    c_NBYTE = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH-1:0] c_LAST  = {ADDR_WIDTH{1'b1}};

  typedef enum logic [0:0] {
    S_CLEAR = 1'b0,
    S_READY = 1'b1
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [ADDR_WIDTH-1:0]   r_clr_cnt;
  logic [ADDR_WIDTH-1:0]   w_clr_cnt_nxt;

  logic [DATA_WIDTH-1:0]   r_mem [c_DEPTH];
  logic [DATA_WIDTH-1:0]   r_rd_data;
  logic                    r_rd_valid;

  logic                    w_mem_we;
  logic [ADDR_WIDTH-1:0]   w_mem_adr;
  logic [DATA_WIDTH-1:0]   w_mem_wdata;
  logic [c_NBYTE-1:0]      w_mem_be;
  logic [DATA_WIDTH-1:0]   w_rd_word;
  logic                    w_rd_accept;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_CLEAR;
      r_clr_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_clr_cnt <= w_clr_cnt_nxt;
    end
  end

  // Completion is an explicit last-address compare, so the counter wrap is harmless.
  always_comb begin
    w_state_nxt   = r_state;
    w_clr_cnt_nxt = r_clr_cnt;
    w_mem_we      = 1'b0;
    w_mem_adr     = bus.wr_adr;
    w_mem_wdata   = bus.wr_data;
    w_mem_be      = bus.wr_be;
    case (r_state)
      S_CLEAR: begin
        w_mem_we      = 1'b1;
        w_mem_adr     = r_clr_cnt;
        w_mem_wdata   = '0;
        w_mem_be      = '1;
        w_clr_cnt_nxt = r_clr_cnt + ADDR_WIDTH'(1);
        if (r_clr_cnt == c_LAST) begin
          w_state_nxt = S_READY;
        end
      end
      default: begin
        w_mem_we = bus.wr_en;
        if (bus.clear_req) begin
          w_state_nxt   = S_CLEAR;
          w_clr_cnt_nxt = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      for (int b = 0; b < c_NBYTE; b++) begin
        if (w_mem_be[b]) begin
          r_mem[w_mem_adr][b*8 +: 8] <= w_mem_wdata[b*8 +: 8];
        end
      end
    end
  end

  generate
    if (RDW_MODE == 1) begin : g_rdw_new
      // Forward enabled write bytes on a same-address collision.
      always_comb begin
        w_rd_word = r_mem[bus.rd_adr];
        if (bus.wr_en && (bus.wr_adr == bus.rd_adr)) begin
          for (int b = 0; b < c_NBYTE; b++) begin
            if (bus.wr_be[b]) begin
              w_rd_word[b*8 +: 8] = bus.wr_data[b*8 +: 8];
            end
          end
        end
      end
    end else begin : g_rdw_old
      assign w_rd_word = r_mem[bus.rd_adr];
    end
  endgenerate

  assign w_rd_accept = (r_state == S_READY) && bus.rd_en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= w_rd_accept;
      if (w_rd_accept) begin
        r_rd_data <= w_rd_word;
      end
    end
  end

  assign bus.busy     = (r_state == S_CLEAR);
  assign bus.rd_data  = r_rd_data;
  assign bus.rd_valid = r_rd_valid;

endmodule

`default_nettype wire

// File: tb/tb_dual_port_ram.sv
// ----------------------------------------------------------------------------
// Module   : tb_dual_port_ram
// Brief    : Directed self-checking bench; u_dut0 uses RDW_MODE=0, u_dut1 RDW_MODE=1.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

module tb_dual_port_ram;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  dual_port_ram_if #(.ADDR_WIDTH(4), .DATA_WIDTH(32)) bus0 ();
  dual_port_ram_if #(.ADDR_WIDTH(4), .DATA_WIDTH(32)) bus1 ();

  assign bus1.clear_req = bus0.clear_req;
  assign bus1.wr_en     = bus0.wr_en;
  assign bus1.wr_adr    = bus0.wr_adr;
  assign bus1.wr_data   = bus0.wr_data;
  assign bus1.wr_be     = bus0.wr_be;
  assign bus1.rd_en     = bus0.rd_en;
  assign bus1.rd_adr    = bus0.rd_adr;

  dual_port_ram #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .RDW_MODE(0)) u_dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus0)
  );

  dual_port_ram #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .RDW_MODE(1)) u_dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [3:0] adr, input logic [31:0] data, input logic [3:0] be);
    bus0.wr_en   = 1'b1;
    bus0.wr_adr  = adr;
    bus0.wr_data = data;
    bus0.wr_be   = be;
    tick();
    bus0.wr_en   = 1'b0;
  endtask

  task automatic do_read(input logic [3:0] adr, output logic [31:0] data, output logic valid);
    bus0.rd_en  = 1'b1;
    bus0.rd_adr = adr;
    tick();
    data        = bus0.rd_data;
    valid       = bus0.rd_valid;
    bus0.rd_en  = 1'b0;
  endtask

  task automatic test_reset();
    int n;
    logic [31:0] d;
    logic v;
    checks++;
    if (bus0.busy !== 1'b1 || bus0.rd_valid !== 1'b0 || bus0.rd_data !== 32'h0) begin
      errors++;
      $display("FAIL reset_state busy=%b rd_valid=%b rd_data=%h required 1 0 00000000",
               bus0.busy, bus0.rd_valid, bus0.rd_data);
    end
    rst_n = 1'b1;
    n = 0;
    while (bus0.busy === 1'b1 && n < 100) begin
      tick();
      n++;
    end
    checks++;
    if (n !== 16) begin
      errors++;
      $display("FAIL reset_busy_cycles got %0d required 16", n);
    end
    for (int a = 0; a < 16; a++) begin
      do_read(4'(a), d, v);
      checks++;
      if (v !== 1'b1 || d !== 32'h0 || bus1.rd_data !== 32'h0) begin
        errors++;
        $display("FAIL reset_zero adr=%0d valid=%b data=%h data1=%h required 1 00000000",
                 a, v, d, bus1.rd_data);
      end
    end
    tick();
    checks++;
    if (bus0.rd_valid !== 1'b0 || bus0.rd_data !== 32'h0) begin
      errors++;
      $display("FAIL idle_after_read rd_valid=%b rd_data=%h required 0 00000000",
               bus0.rd_valid, bus0.rd_data);
    end
  endtask

  task automatic test_byte_enable();
    logic [31:0] d;
    logic v;
    do_write(4'd3, 32'hDEADBEEF, 4'b1111);
    do_write(4'd3, 32'h11223344, 4'b0101);
    do_read(4'd3, d, v);
    checks++;
    if (v !== 1'b1 || d !== 32'hDE22BE44) begin
      errors++;
      $display("FAIL byte_enable valid=%b data=%h required 1 DE22BE44", v, d);
    end
    do_write(4'd3, 32'hFFFFFFFF, 4'b0000);
    do_read(4'd3, d, v);
    checks++;
    if (d !== 32'hDE22BE44) begin
      errors++;
      $display("FAIL be_zero data=%h required DE22BE44", d);
    end
    tick();
    checks++;
    if (bus0.rd_valid !== 1'b0 || bus0.rd_data !== 32'hDE22BE44) begin
      errors++;
      $display("FAIL rd_hold rd_valid=%b rd_data=%h required 0 DE22BE44",
               bus0.rd_valid, bus0.rd_data);
    end
  endtask

  task automatic test_rdw();
    logic [31:0] d;
    logic v;
    do_write(4'd5, 32'hAAAAAAAA, 4'b1111);
    bus0.wr_en = 1'b1; bus0.wr_adr = 4'd5; bus0.wr_data = 32'h55555555; bus0.wr_be = 4'b1111;
    do_read(4'd5, d, v);
    bus0.wr_en = 1'b0;
    checks++;
    if (d !== 32'hAAAAAAAA || bus1.rd_data !== 32'h55555555) begin
      errors++;
      $display("FAIL rdw_full mode0=%h mode1=%h required AAAAAAAA 55555555", d, bus1.rd_data);
    end
    do_read(4'd5, d, v);
    checks++;
    if (d !== 32'h55555555 || bus1.rd_data !== 32'h55555555) begin
      errors++;
      $display("FAIL rdw_after mode0=%h mode1=%h required 55555555", d, bus1.rd_data);
    end
    do_write(4'd5, 32'hAAAAAAAA, 4'b1111);
    bus0.wr_en = 1'b1; bus0.wr_adr = 4'd5; bus0.wr_data = 32'h55555555; bus0.wr_be = 4'b0011;
    do_read(4'd5, d, v);
    bus0.wr_en = 1'b0;
    checks++;
    if (d !== 32'hAAAAAAAA || bus1.rd_data !== 32'hAAAA5555) begin
      errors++;
      $display("FAIL rdw_partial mode0=%h mode1=%h required AAAAAAAA AAAA5555", d, bus1.rd_data);
    end
    do_read(4'd5, d, v);
    checks++;
    if (d !== 32'hAAAA5555 || bus1.rd_data !== 32'hAAAA5555) begin
      errors++;
      $display("FAIL rdw_partial_after mode0=%h mode1=%h required AAAA5555", d, bus1.rd_data);
    end
    // different addresses in the same cycle
    bus0.wr_en = 1'b1; bus0.wr_adr = 4'd6; bus0.wr_data = 32'h12345678; bus0.wr_be = 4'b1111;
    do_read(4'd3, d, v);
    bus0.wr_en = 1'b0;
    checks++;
    if (d !== 32'hDE22BE44 || bus1.rd_data !== 32'hDE22BE44) begin
      errors++;
      $display("FAIL indep_read mode0=%h mode1=%h required DE22BE44", d, bus1.rd_data);
    end
    do_read(4'd6, d, v);
    checks++;
    if (d !== 32'h12345678) begin
      errors++;
      $display("FAIL indep_write data=%h required 12345678", d);
    end
  endtask

  task automatic test_clear();
    logic [31:0] d;
    logic v;
    int n;
    for (int a = 0; a < 16; a++) begin
      do_write(4'(a), {28'hF00D000, 4'(a)}, 4'b1111);
    end
    bus0.clear_req = 1'b1;
    do_read(4'd7, d, v);
    checks++;
    if (v !== 1'b1 || d !== 32'hF00D0007 || bus0.busy !== 1'b1) begin
      errors++;
      $display("FAIL clear_req_read valid=%b data=%h busy=%b required 1 F00D0007 1", v, d, bus0.busy);
    end
    bus0.wr_en = 1'b1; bus0.wr_adr = 4'd4; bus0.wr_data = 32'hFFFFFFFF; bus0.wr_be = 4'b1111;
    bus0.rd_en = 1'b1; bus0.rd_adr = 4'd4;
    n = 1;
    while (bus0.busy === 1'b1 && n < 100) begin
      tick();
      if (bus0.busy === 1'b0) bus0.clear_req = 1'b0;
      n++;
      checks++;
      if (bus0.rd_valid !== 1'b0 || bus0.rd_data !== 32'hF00D0007) begin
        errors++;
        $display("FAIL busy_ignored cycle=%0d rd_valid=%b rd_data=%h required 0 F00D0007",
                 n, bus0.rd_valid, bus0.rd_data);
      end
    end
    bus0.clear_req = 1'b0;
    bus0.wr_en = 1'b0;
    bus0.rd_en = 1'b0;
    checks++;
    if (n !== 17) begin
      errors++;
      $display("FAIL clear_busy_cycles got %0d required 16", n - 1);
    end
    for (int a = 0; a < 16; a++) begin
      do_read(4'(a), d, v);
      checks++;
      if (v !== 1'b1 || d !== 32'h0) begin
        errors++;
        $display("FAIL clear_zero adr=%0d valid=%b data=%h required 1 00000000", a, v, d);
      end
    end
  endtask

  task automatic test_reset_mid_clear();
    logic [31:0] d;
    logic v;
    int n;
    do_write(4'd1, 32'hCAFEF00D, 4'b1111);
    do_write(4'd9, 32'h99999999, 4'b1111);
    do_read(4'd1, d, v);
    bus0.clear_req = 1'b1;
    tick();
    bus0.clear_req = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus0.busy !== 1'b1 || bus0.rd_valid !== 1'b0 || bus0.rd_data !== 32'h0) begin
      errors++;
      $display("FAIL mid_clear_reset busy=%b rd_valid=%b rd_data=%h required 1 0 00000000",
               bus0.busy, bus0.rd_valid, bus0.rd_data);
    end
    tick();
    tick();
    rst_n = 1'b1;
    n = 0;
    while (bus0.busy === 1'b1 && n < 100) begin
      tick();
      n++;
    end
    checks++;
    if (n !== 16) begin
      errors++;
      $display("FAIL restart_busy_cycles got %0d required 16", n);
    end
    do_read(4'd9, d, v);
    checks++;
    if (v !== 1'b1 || d !== 32'h0) begin
      errors++;
      $display("FAIL restart_zero valid=%b data=%h required 1 00000000", v, d);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_d;
    for (int a = 0; a < 16; a++) begin
      do_write(4'(a), {16'hB2B0, 12'h000, 4'(a)}, 4'b1111);
    end
    bus0.rd_en = 1'b1;
    for (int a = 0; a < 16; a++) begin
      bus0.rd_adr = 4'(a);
      tick();
      exp_d = {16'hB2B0, 12'h000, 4'(a)};
      checks++;
      if (bus0.rd_valid !== 1'b1 || bus0.rd_data !== exp_d) begin
        errors++;
        $display("FAIL back_to_back adr=%0d rd_valid=%b rd_data=%h required 1 %h",
                 a, bus0.rd_valid, bus0.rd_data, exp_d);
      end
    end
    bus0.rd_en = 1'b0;
    tick();
    checks++;
    if (bus0.rd_valid !== 1'b0 || bus0.rd_data !== 32'hB2B0000F) begin
      errors++;
      $display("FAIL b2b_end rd_valid=%b rd_data=%h required 0 B2B0000F",
               bus0.rd_valid, bus0.rd_data);
    end
  endtask

  initial begin
    checks         = 0;
    errors         = 0;
    rst_n          = 1'b0;
    bus0.clear_req = 1'b0;
    bus0.wr_en     = 1'b0;
    bus0.wr_adr    = '0;
    bus0.wr_data   = '0;
    bus0.wr_be     = '0;
    bus0.rd_en     = 1'b0;
    bus0.rd_adr    = '0;
    tick();
    tick();
    test_reset();
    test_byte_enable();
    test_rdw();
    test_clear();
    test_reset_mid_clear();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
